uart_axi_burst_writer: RTL and testbench

//  Write-side partner of the debug AXI burst reader. Collects words from the UART receive word

---
 rtl/uart_axi_burst_writer.sv | 179 +++++++++++++++++
 tb/tb_uart_axi_burst_writer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_axi_burst_writer.sv
// UART-to-AXI4 burst writer: buffers DATA_DEPTH received words, then writes them to DDR as one INCR burst.
// Define WRITER_BRESP_CHECK_EN to abort the session with a sticky err on a non-OKAY write response.
module uart_axi_burst_writer #(
    parameter int  TOTAL_PACKAGE   = 416,
    parameter int  DATA_DEPTH      = 16,
    parameter int  DATA_BYTE_SHIFT = 5,
    parameter int  DATA_BYTE_WIDTH = 32,
    localparam int DATA_BIT_WIDTH  = DATA_BYTE_WIDTH * 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       write_start,
    input  logic [31:0]                write_addr_start,
    input  logic [DATA_BIT_WIDTH-1:0]  rx_data,
    input  logic                       rx_rdy,
    output logic                       rx_ack,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic [9:0]                 beats_written,
    output logic [3:0]                 axi_awid,
    output logic [31:0]                axi_awaddr,
    output logic [7:0]                 axi_awlen,
    output logic [2:0]                 axi_awsize,
    output logic [1:0]                 axi_awburst,
    output logic                       axi_awvalid,
    input  logic                       axi_awready,
    output logic [DATA_BIT_WIDTH-1:0]  axi_wdata,
    output logic [DATA_BYTE_WIDTH-1:0] axi_wstrb,
    output logic                       axi_wlast,
    output logic                       axi_wvalid,
    input  logic                       axi_wready,
    input  logic [3:0]                 axi_bid,
    input  logic [1:0]                 axi_bresp,
    input  logic                       axi_bvalid,
    output logic                       axi_bready
);

    localparam int               IDX_W     = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_DEPTH - 1);
    localparam logic [9:0]       DEPTH_CNT = 10'(DATA_DEPTH);
    localparam logic [9:0]       TOTAL_CNT = 10'(TOTAL_PACKAGE);

    typedef enum logic [2:0] {S_IDLE, S_FILL, S_AW, S_W, S_B} state_t;

    state_t                    state, state_next;
    logic [DATA_BIT_WIDTH-1:0] buffer [DATA_DEPTH];
    logic [IDX_W-1:0]          fill_idx, beat_idx;
    logic [31:0]               start_addr;
    logic                      fill_hs, aw_hs, w_hs, b_hs;
    logic                      last_fill, last_beat, final_burst, bresp_bad;

    assign axi_awid    = 4'd0;
    assign axi_awlen   = 8'(DATA_DEPTH - 1);
    assign axi_awsize  = 3'(DATA_BYTE_SHIFT);
    assign axi_awburst = 2'b01;
    assign axi_wstrb   = '1;

    assign fill_hs     = rx_rdy && rx_ack;
    assign aw_hs       = axi_awvalid && axi_awready;
    assign w_hs        = axi_wvalid && axi_wready;
    assign b_hs        = axi_bvalid && axi_bready;
    assign last_fill   = fill_hs && (fill_idx == LAST_IDX);
    assign last_beat   = w_hs && (beat_idx == LAST_IDX);
    assign final_burst = (beats_written + DEPTH_CNT) == TOTAL_CNT;

`ifdef WRITER_BRESP_CHECK_EN
    logic unused_bid;
    assign unused_bid = ^axi_bid;
    assign bresp_bad  = axi_bresp != 2'b00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err <= 1'b0;
        else if (state == S_IDLE && write_start)
            err <= 1'b0;
        else if (state == S_B && b_hs && bresp_bad)
            err <= 1'b1;
    end
`else
    logic unused_b;
    assign unused_b  = ^{axi_bid, axi_bresp};
    assign bresp_bad = 1'b0;
    assign err       = 1'b0;
`endif

    // NOTE: sequential state uses <= so every register samples pre-edge values, whatever the block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (write_start) state_next = S_FILL;
            S_FILL:  if (last_fill)   state_next = S_AW;
            S_AW:    if (aw_hs)       state_next = S_W;
            S_W:     if (last_beat)   state_next = S_B;
            S_B:     if (b_hs)        state_next = (bresp_bad || final_burst) ? S_IDLE : S_FILL;
            default: state_next = S_IDLE;
        endcase
    end

    // NOTE: every output gets a default first so no path through this block can infer a latch.
    always_comb begin
        busy        = 1'b0;
        rx_ack      = 1'b0;
        axi_awvalid = 1'b0;
        axi_wvalid  = 1'b0;
        axi_wlast   = 1'b0;
        axi_bready  = 1'b0;
        axi_wdata   = '0;
        case (state)
            S_FILL: begin
                busy   = 1'b1;
                rx_ack = 1'b1;
            end
            S_AW: begin
                busy        = 1'b1;
                axi_awvalid = 1'b1;
            end
            S_W: begin
                busy       = 1'b1;
                axi_wvalid = 1'b1;
                axi_wlast  = beat_idx == LAST_IDX;
                axi_wdata  = buffer[beat_idx];
            end
            S_B: begin
                busy       = 1'b1;
                axi_bready = 1'b1;
            end
            default: ;
        endcase
    end

    // Burst address is computed as the last word lands, so awaddr is already valid when AW is entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_addr    <= '0;
            fill_idx      <= '0;
            beat_idx      <= '0;
            beats_written <= '0;
            axi_awaddr    <= '0;
            done          <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: if (write_start) begin
                    start_addr    <= write_addr_start;
                    fill_idx      <= '0;
                    beat_idx      <= '0;
                    beats_written <= '0;
                end
                S_FILL: if (fill_hs) begin
                    fill_idx <= (fill_idx == LAST_IDX) ? '0 : fill_idx + 1'b1;
                    if (fill_idx == LAST_IDX)
                        axi_awaddr <= start_addr + ({22'd0, beats_written} << DATA_BYTE_SHIFT);
                end
                S_W: if (w_hs)
                    beat_idx <= (beat_idx == LAST_IDX) ? '0 : beat_idx + 1'b1;
                S_B: if (b_hs && !bresp_bad) begin
                    beats_written <= beats_written + DEPTH_CNT;
                    done          <= final_burst;
                end
                default: ;
            endcase
        end
    end

    // NOTE: the buffer has no reset; every entry is written in FILL before W can read it.
    always_ff @(posedge clk) begin
        if (fill_hs)
            buffer[fill_idx] <= rx_data;
    end

endmodule

// File: tb/tb_uart_axi_burst_writer.sv
// Self-checking bench for uart_axi_burst_writer: table of session vectors driven by a UART source and
// an AXI slave agent, with a queue-based reference model of addresses, data order and completion.
module tb_uart_axi_burst_writer;

    localparam int TOTAL  = 416;
    localparam int DEPTH  = 16;
    localparam int DBYTES = 32;
    localparam int DBW    = DBYTES * 8;
    localparam int STRIDE = DEPTH * DBYTES;

    logic              clk, rst_n;
    logic              write_start;
    logic [31:0]       write_addr_start;
    logic [DBW-1:0]    rx_data;
    logic              rx_rdy, rx_ack, busy, done, err;
    logic [9:0]        beats_written;
    logic [3:0]        axi_awid;
    logic [31:0]       axi_awaddr;
    logic [7:0]        axi_awlen;
    logic [2:0]        axi_awsize;
    logic [1:0]        axi_awburst;
    logic              axi_awvalid, axi_awready;
    logic [DBW-1:0]    axi_wdata;
    logic [DBYTES-1:0] axi_wstrb;
    logic              axi_wlast, axi_wvalid, axi_wready;
    logic [3:0]        axi_bid;
    logic [1:0]        axi_bresp;
    logic              axi_bvalid, axi_bready;

    uart_axi_burst_writer dut (
        .clk(clk), .rst_n(rst_n), .write_start(write_start), .write_addr_start(write_addr_start),
        .rx_data(rx_data), .rx_rdy(rx_rdy), .rx_ack(rx_ack), .busy(busy), .done(done), .err(err),
        .beats_written(beats_written), .axi_awid(axi_awid), .axi_awaddr(axi_awaddr),
        .axi_awlen(axi_awlen), .axi_awsize(axi_awsize), .axi_awburst(axi_awburst),
        .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_wdata(axi_wdata),
        .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast), .axi_wvalid(axi_wvalid),
        .axi_wready(axi_wready), .axi_bid(axi_bid), .axi_bresp(axi_bresp),
        .axi_bvalid(axi_bvalid), .axi_bready(axi_bready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] start;
        int          aw_hold;    // cycles awready stays low once awvalid rises
        bit          w_toggle;   // wready alternates 1/0
        bit          rand_gaps;  // random rx_rdy / ready / bvalid gaps
        int          err_burst;  // burst index answered with SLVERR, -1 for none
        int          exp_bursts;
        int          exp_beats;
        int          exp_done;
        int          exp_err;
    } vec_t;

    vec_t vecs [5];

    int n_tests = 0;
    int n_fail  = 0;

    // Agent / model state
    logic [DBW-1:0] rx_q[$], sent_q[$], w_q[$];
    logic [31:0]    aw_q[$];
    logic [31:0]    prev_awaddr;
    int  aw_hs_cnt, w_beats, b_cnt, pending_b, fill_cnt, done_cnt;
    int  viol, lat_bad, aw_wait, aw_dur, aw_dur_bad, cyc;
    bit  prev_fill_last, prev_aw_hs, prev_wlast_hs, prev_aw_pending;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic idle_inputs();
        write_start = 1'b0;
        rx_rdy      = 1'b0;
        rx_data     = '0;
        axi_awready = 1'b0;
        axi_wready  = 1'b0;
        axi_bvalid  = 1'b0;
        axi_bresp   = 2'b00;
        axi_bid     = 4'd0;
    endtask

    task automatic drive(input vec_t v);
        rx_rdy  = (rx_q.size() > 0) && (!v.rand_gaps || $urandom_range(0, 3) != 0);
        rx_data = (rx_q.size() > 0) ? rx_q[0] : '0;
        if (v.rand_gaps)
            axi_awready = 1'($urandom_range(0, 1));
        else
            axi_awready = aw_wait >= v.aw_hold;
        if (v.w_toggle)
            axi_wready = cyc[0];
        else if (v.rand_gaps)
            axi_wready = 1'($urandom_range(0, 1));
        else
            axi_wready = 1'b1;
        axi_bvalid = (pending_b > 0) && (!v.rand_gaps || $urandom_range(0, 1) == 1);
        axi_bresp  = (b_cnt == v.err_burst) ? 2'b10 : 2'b00;
        axi_bid    = 4'($urandom);
    endtask

    // Observes the handshakes that the coming rising edge will complete.
    task automatic observe(input vec_t v);
        bit fill_h, aw_h, w_h, b_h;
        fill_h = rx_rdy && rx_ack;
        aw_h   = axi_awvalid && axi_awready;
        w_h    = axi_wvalid && axi_wready;
        b_h    = axi_bvalid && axi_bready;

        if (prev_fill_last && !axi_awvalid) lat_bad++;
        if (prev_aw_hs && !axi_wvalid)      lat_bad++;
        if (prev_wlast_hs && !axi_bready)   lat_bad++;
        if (rx_ack && (axi_awvalid || axi_wvalid || axi_bready)) viol++;
        if (prev_aw_pending && (!axi_awvalid || axi_awaddr != prev_awaddr)) viol++;
        if (axi_wvalid && w_beats >= aw_hs_cnt * DEPTH) viol++;
        if (axi_wvalid && (axi_wlast != ((w_beats % DEPTH) == DEPTH - 1))) viol++;
        if (axi_wlast && !axi_wvalid) viol++;
        if (axi_awvalid && (axi_awlen != 8'(DEPTH - 1) || axi_awsize != 3'd5 ||
                            axi_awburst != 2'b01 || axi_awid != 4'd0)) viol++;
        if (axi_wvalid && axi_wstrb != '1) viol++;
        if (done) done_cnt++;

        if (fill_h) begin
            sent_q.push_back(rx_q.pop_front());
            fill_cnt++;
        end
        prev_fill_last = fill_h && (fill_cnt % DEPTH == 0);

        if (axi_awvalid) begin
            aw_dur++;
            if (aw_h) begin
                aw_q.push_back(axi_awaddr);
                if (!v.rand_gaps && aw_dur != v.aw_hold + 1) aw_dur_bad++;
                aw_dur  = 0;
                aw_wait = 0;
                aw_hs_cnt++;
            end else begin
                aw_wait++;
            end
        end
        prev_aw_hs      = aw_h;
        prev_aw_pending = axi_awvalid && !aw_h;
        prev_awaddr     = axi_awaddr;

        if (w_h) begin
            w_q.push_back(axi_wdata);
            w_beats++;
            if (axi_wlast) pending_b++;
        end
        prev_wlast_hs = w_h && axi_wlast;

        if (b_h) begin
            pending_b--;
            b_cnt++;
        end
    endtask

    task automatic run_session(input vec_t v, input int vi, input int stop_beats);
        logic [DBW-1:0] word;
        logic [31:0]    exp_addr;
        bit             finished;
        int             bad;
        rx_q.delete(); sent_q.delete(); w_q.delete(); aw_q.delete();
        aw_hs_cnt = 0; w_beats = 0; b_cnt = 0; pending_b = 0; fill_cnt = 0; done_cnt = 0;
        viol = 0; lat_bad = 0; aw_wait = 0; aw_dur = 0; aw_dur_bad = 0;
        prev_fill_last = 0; prev_aw_hs = 0; prev_wlast_hs = 0; prev_aw_pending = 0;
        prev_awaddr = '0;
        finished = 0;
        for (int i = 0; i < TOTAL; i++) begin
            if (vi == 0)
                word = DBW'(i);
            else
                for (int j = 0; j < DBW / 32; j++) word[j*32 +: 32] = $urandom;
            rx_q.push_back(word);
        end

        for (int c = 0; c < 30000; c++) begin
            @(negedge clk);
            cyc              = c;
            write_start      = (c == 0) || (v.rand_gaps && $urandom_range(0, 7) == 0);
            write_addr_start = (c == 0) ? v.start : $urandom;
            drive(v);
            #1;
            observe(v);
            if (stop_beats > 0 && w_beats >= stop_beats) begin
                write_start = 1'b0;
                return;
            end
            if (c > 0 && !busy) begin
                finished = 1;
                break;
            end
        end
        idle_inputs();
        check($sformatf("v%0d_session_ends", vi), finished, 1);

        check($sformatf("v%0d_aw_count", vi), aw_q.size(), v.exp_bursts);
        bad = 0;
        foreach (aw_q[k]) begin
            exp_addr = v.start + 32'(k * STRIDE);
            if (aw_q[k] != exp_addr) bad++;
        end
        check($sformatf("v%0d_awaddr_seq_bad", vi), bad, 0);
        check($sformatf("v%0d_w_beats", vi), w_q.size(), v.exp_bursts * DEPTH);
        check($sformatf("v%0d_rx_words_taken", vi), sent_q.size(), v.exp_bursts * DEPTH);
        bad = 0;
        for (int i = 0; i < w_q.size() && i < sent_q.size(); i++)
            if (w_q[i] !== sent_q[i]) bad++;
        check($sformatf("v%0d_wdata_order_bad", vi), bad, 0);
        check($sformatf("v%0d_b_count", vi), b_cnt, v.exp_bursts);
        check($sformatf("v%0d_beats_written", vi), beats_written, v.exp_beats);
        check($sformatf("v%0d_done_pulses", vi), done_cnt, v.exp_done);
        check($sformatf("v%0d_err", vi), err, v.exp_err);
        check($sformatf("v%0d_busy_after", vi), busy, 0);
        check($sformatf("v%0d_protocol_bad", vi), viol, 0);
        check($sformatf("v%0d_latency_bad", vi), lat_bad, 0);
        check($sformatf("v%0d_aw_stall_bad", vi), aw_dur_bad, 0);
    endtask

    initial begin
        // start, aw_hold, w_toggle, rand, err_burst, bursts, beats, done, err
        vecs[0] = '{32'h1000_0000, 0, 1'b0, 1'b0, -1, TOTAL / DEPTH, TOTAL, 1, 0};
        vecs[1] = '{32'h2000_0000, 5, 1'b0, 1'b0, -1, TOTAL / DEPTH, TOTAL, 1, 0};
        vecs[2] = '{32'h3000_0100, 0, 1'b1, 1'b0, -1, TOTAL / DEPTH, TOTAL, 1, 0};
        vecs[3] = '{32'hFFFF_F000, 0, 1'b0, 1'b1, -1, TOTAL / DEPTH, TOTAL, 1, 0};
`ifdef WRITER_BRESP_CHECK_EN
        vecs[4] = '{32'h4000_0000, 0, 1'b0, 1'b0, 2, 3, 2 * DEPTH, 0, 1};
`else
        vecs[4] = '{32'h4000_0000, 0, 1'b0, 1'b0, 2, TOTAL / DEPTH, TOTAL, 1, 0};
`endif

        rst_n = 1'b0;
        write_addr_start = '0;
        idle_inputs();
        repeat (3) @(negedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_valids_ready", {axi_awvalid, axi_wvalid, axi_wlast, axi_bready, rx_ack}, 0);
        check("rst_done_err", {done, err}, 0);
        check("rst_beats_written", beats_written, 0);
        check("rst_awaddr", axi_awaddr, 0);
        check("rst_wdata_nonzero", |axi_wdata, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int vi = 0; vi < 5; vi++)
            run_session(vecs[vi], vi, 0);

        // Reset asserted mid-way through the second burst's W phase.
        run_session(vecs[1], 5, DEPTH + 5);
        #2;
        check("pre_rst_wvalid", axi_wvalid, 1);
        check("pre_rst_beats_written", beats_written, DEPTH);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valids_ready", {axi_awvalid, axi_wvalid, axi_wlast, axi_bready, rx_ack}, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_beats_written", beats_written, 0);
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_session(vecs[0], 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
